lcd_timing: RTL and testbench
=============================

# lcd_timing

Raster timing generator for the parallel RGB LCD panel. Walks the full horizontal/vertical raster and drives the `x`/`y` pixel coordinates consumed directly by the pixel/test-pattern stage. It produces panel sync and data-enable signals delayed by a configurable number of pixel cycles, so they line up with that stage's registered font-ROM output. Sits directly upstream of the pattern generator and alongside it at the panel pins.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FRONT`, 40, horizontal front porch (pixels)
- `H_SYNC`, 48, hsync width (pixels)
- `H_BACK`, 88, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 13, vertical front porch (lines)
- `V_SYNC`, 3, vsync width (lines)
- `V_BACK`, 32, vertical back porch (lines)
- `HS_ACTIVE_LOW`, 1, hsync polarity (1 = asserted low)
- `VS_ACTIVE_LOW`, 1, vsync polarity (1 = asserted low)
- `SYNC_DELAY`, 1, pipeline depth applied to `lcd_hs`/`lcd_vs`/`lcd_de`, legal 0..4
- `clock`  in  1  pixel-domain clock, single clock domain
- `reset`  in  1  synchronous, active-high reset
- `pixel_enable`  in  1  advance one pixel this cycle
- `x`  out  10  raster column, 0..H_TOTAL-1, H_TOTAL = sum of H_* (976)
- `y`  out  10  raster line, 0..V_TOTAL-1, V_TOTAL = sum of V_* (528)
- `active`  out  1  (x,y) inside visible area, undelayed
- `frame_start`  out  1  one-cycle pulse at start of each frame, undelayed
- `lcd_hs`  out  1  panel hsync, delayed by SYNC_DELAY enabled cycles
- `lcd_vs`  out  1  panel vsync, delayed
- `lcd_de`  out  1  panel data enable, delayed

## Operation
- Each line is ordered active, front porch, sync, back porch. Each frame is ordered the same way in lines.
- On an enabled cycle, `x` increments. At `x == H_TOTAL-1` it wraps to 0 and `y` increments. At `y == V_TOTAL-1` with the x-wrap, `y` wraps to 0.
- `pixel_enable` low: counters and the delay line hold. Outputs hold their value.
- `active` = `x < H_ACTIVE && y < V_ACTIVE`. This is combinational from the counter registers.
- Raw hsync is asserted for `H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC`, i.e. 840..887.
- Raw vsync is asserted for `V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC`, i.e. 493..495, for every x of those lines.
- Polarity parameters are applied before the delay line.
- `frame_start` = `x == 0 && y == 0 && pixel_enable`. It gives exactly one pulse per frame regardless of enable duty.
- Delay line: {hs, vs, de} shift register of depth SYNC_DELAY, advancing only on enabled cycles.
  - SYNC_DELAY = 0: `lcd_*` are combinational decodes of the counters.
- Width rules: all comparisons use 10-bit unsigned values.
  - Parameter sums must fit in 10 bits (H_TOTAL, V_TOTAL ≤ 1024). Violation is an elaboration error.

## Timing
- Reset values:
  - `x`=0, `y`=0, `active`=1 (decoded from 0,0).
  - `lcd_hs`/`lcd_vs` at the inactive level (1 when active-low), `lcd_de`=0.
  - All delay stages are loaded with the inactive {hs, vs, de}.
- `frame_start` is 1 in the first enabled cycle after reset.
- Reset mid-frame: the next cycle shows x=y=0, and the delay line is flushed to inactive. No partial sync pulse is emitted after reset deasserts except one generated from the new counter state.
- Reset dominates `pixel_enable`.
- Latency:
  - `x`/`y`/`active`/`frame_start` reflect the current counter state with 0 cycles latency.
  - `lcd_*` for counter state (x,y) appear SYNC_DELAY enabled cycles later. With the default of 1, they match a downstream stage having one registered cycle.
- Frame period: H_TOTAL×V_TOTAL = 515328 enabled cycles. `lcd_de` is high for 384000 of them.
- Simultaneous x-wrap and y-wrap: both counters are 0 in the next enabled cycle, and `frame_start` asserts there.

## Structure
- Shared package `lcd_pkg` holds:
  - the panel timing constants (defaults above),
  - derived H_TOTAL/V_TOTAL and sync start/end localparams,
  - the coordinate width (10).
- One sub-module, `sync_delay`: a parameterised-depth, enable-gated shift register with synchronous reset value input. It carries {hs, vs, de} and handles depth 0 as a pass-through.
- Counters and decodes live in `lcd_timing` itself.

## Test plan
- Reset, then `pixel_enable`=1 constantly:
  - x runs 0..975 and wraps, and y increments at each wrap;
  - after 515328 cycles the counters return to (0,0) with `frame_start`=1;
  - `frame_start` is seen exactly once per frame.
- Defaults, SYNC_DELAY=1:
  - `lcd_hs` is low for 48 consecutive cycles, starting the cycle after x=840;
  - `lcd_vs` is low for 3×976 cycles, starting one cycle after (x=0, y=493).
- `lcd_de` high count per frame = 384000, every line's run is exactly 800 cycles, and `active` is high for x<800 && y<480.
- `pixel_enable` toggled pseudo-randomly at 50%:
  - counters and all `lcd_*` hold on low cycles;
  - the enabled-cycle sequence is identical to the always-enabled run.
- Assert `reset` for one cycle at (x=500, y=300) during vsync-free active video: next cycle x=y=0, `lcd_de`=0, `lcd_hs`=`lcd_vs`=1.
- SYNC_DELAY=0 and SYNC_DELAY=3 builds:
  - the `lcd_*` edges shift by exactly 0 and 3 cycles relative to the counter decode;
  - HS_ACTIVE_LOW=0 inverts `lcd_hs` only.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared panel timing constants, coordinate type and sync-pin bundle for the
// LCD raster timing generator.
package lcd_pkg;

    localparam int COORD_W   = 10;
    localparam int COORD_MAX = (1 << COORD_W);

    typedef logic [COORD_W-1:0] coord_t;

    localparam int LCD_H_ACTIVE = 800;
    localparam int LCD_H_FRONT  = 40;
    localparam int LCD_H_SYNC   = 48;
    localparam int LCD_H_BACK   = 88;
    localparam int LCD_V_ACTIVE = 480;
    localparam int LCD_V_FRONT  = 13;
    localparam int LCD_V_SYNC   = 3;
    localparam int LCD_V_BACK   = 32;

    localparam int LCD_H_TOTAL  = LCD_H_ACTIVE + LCD_H_FRONT + LCD_H_SYNC + LCD_H_BACK;
    localparam int LCD_V_TOTAL  = LCD_V_ACTIVE + LCD_V_FRONT + LCD_V_SYNC + LCD_V_BACK;

    localparam int LCD_HS_START = LCD_H_ACTIVE + LCD_H_FRONT;
    localparam int LCD_HS_END   = LCD_HS_START + LCD_H_SYNC;
    localparam int LCD_VS_START = LCD_V_ACTIVE + LCD_V_FRONT;
    localparam int LCD_VS_END   = LCD_VS_START + LCD_V_SYNC;

    // Panel-side pins carried together through the delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } pins_t;

    localparam int PINS_W = $bits(pins_t);

    // Inclusive window test; inclusive bounds keep every limit inside COORD_W bits.
    function automatic logic in_window(input coord_t v, input coord_t first, input coord_t last);
        return (v >= first) && (v <= last);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Enable-gated shift register of configurable depth with a synchronous reset
// value; depth 0 degenerates to a wire.
module sync_delay #(
    parameter int DATA_W = 3,
    parameter int STAGES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] rst_value,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    if (STAGES < 0) begin : g_bad_depth
        $error("sync_delay: STAGES must be non-negative");
    end

    if (STAGES == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_pipe
        logic [DATA_W-1:0] stage_q [STAGES];
        logic [DATA_W-1:0] stage_d [STAGES];

        always_comb begin
            for (int i = 0; i < STAGES; i++) begin
                stage_d[i] = stage_q[i];
            end
            if (enable) begin
                stage_d[0] = din;
                for (int i = 1; i < STAGES; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        // Reset loads the idle pin levels so no stale pulse leaks out afterwards.
        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < STAGES; i++) begin
                    stage_q[i] <= rst_value;
                end
            end else begin
                for (int i = 0; i < STAGES; i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign dout = stage_q[STAGES-1];
    end

endmodule

// File: rtl/lcd_timing.sv
// Raster timing generator: walks the panel raster, exposes live x/y/active for
// the pattern stage and delays hs/vs/de to match that stage's pipeline.
module lcd_timing
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE      = LCD_H_ACTIVE,
    parameter int H_FRONT       = LCD_H_FRONT,
    parameter int H_SYNC        = LCD_H_SYNC,
    parameter int H_BACK        = LCD_H_BACK,
    parameter int V_ACTIVE      = LCD_V_ACTIVE,
    parameter int V_FRONT       = LCD_V_FRONT,
    parameter int V_SYNC        = LCD_V_SYNC,
    parameter int V_BACK        = LCD_V_BACK,
    parameter bit HS_ACTIVE_LOW = 1'b1,
    parameter bit VS_ACTIVE_LOW = 1'b1,
    parameter int SYNC_DELAY    = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pixel_enable,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               frame_start,
    output logic               lcd_hs,
    output logic               lcd_vs,
    output logic               lcd_de
);

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int VS_START = V_ACTIVE + V_FRONT;

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
        $error("lcd_timing: H_TOTAL and V_TOTAL must fit in the coordinate width");
    end
    if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_widths
        $error("lcd_timing: active and sync widths must be at least 1");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
        $error("lcd_timing: SYNC_DELAY must be in 0..4");
    end

    // Inclusive last-value limits so a full 1024-wide raster never overflows the compare.
    localparam coord_t X_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t Y_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t X_ACT_LAST = coord_t'(H_ACTIVE - 1);
    localparam coord_t Y_ACT_LAST = coord_t'(V_ACTIVE - 1);
    localparam coord_t HS_FIRST   = coord_t'(HS_START);
    localparam coord_t HS_LAST    = coord_t'(HS_START + H_SYNC - 1);
    localparam coord_t VS_FIRST   = coord_t'(VS_START);
    localparam coord_t VS_LAST    = coord_t'(VS_START + V_SYNC - 1);

    localparam pins_t IDLE_PINS = '{hs: HS_ACTIVE_LOW, vs: VS_ACTIVE_LOW, de: 1'b0};

    coord_t x_q, x_d;
    coord_t y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pixel_enable) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign active      = in_window(x_q, '0, X_ACT_LAST) && in_window(y_q, '0, Y_ACT_LAST);
    assign frame_start = (x_q == '0) && (y_q == '0) && pixel_enable;

    pins_t pol_pins;
    pins_t out_pins;

    // Polarity is folded in ahead of the delay so the line holds panel levels.
    always_comb begin
        pol_pins.hs = in_window(x_q, HS_FIRST, HS_LAST) ^ HS_ACTIVE_LOW;
        pol_pins.vs = in_window(y_q, VS_FIRST, VS_LAST) ^ VS_ACTIVE_LOW;
        pol_pins.de = active;
    end

    sync_delay #(
        .DATA_W (PINS_W),
        .STAGES (SYNC_DELAY)
    ) u_sync_delay (
        .clock     (clock),
        .reset     (reset),
        .enable    (pixel_enable),
        .rst_value (IDLE_PINS),
        .din       (pol_pins),
        .dout      (out_pins)
    );

    assign lcd_hs = out_pins.hs;
    assign lcd_vs = out_pins.vs;
    assign lcd_de = out_pins.de;

endmodule

// File: tb/tb_lcd_timing.sv
// Bench for lcd_timing: four builds (default panel plus three small rasters with
// delays 1/0/3) checked every cycle against an enabled-cycle-count model.
module tb_lcd_timing;

    localparam int S_HA = 8;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 4;
    localparam int S_VA = 5;
    localparam int S_VF = 1;
    localparam int S_VS = 2;
    localparam int S_VB = 2;

    typedef struct {
        int ha, hf, hsw, hb;
        int va, vf, vsw, vb;
        bit hal, val;
        int d;
    } cfg_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pixel_enable = 1'b0;

    logic [9:0] xo [4];
    logic [9:0] yo [4];
    logic aco [4];
    logic fso [4];
    logic hso [4];
    logic vso [4];
    logic deo [4];

    cfg_t cfg [4];
    int   n_en;
    bit   model_ok;
    int   n_total;
    int   n_pass;

    always #5 clk = ~clk;

    lcd_timing u_dflt (
        .clock(clk), .reset(reset), .pixel_enable(pixel_enable),
        .x(xo[0]), .y(yo[0]), .active(aco[0]), .frame_start(fso[0]),
        .lcd_hs(hso[0]), .lcd_vs(vso[0]), .lcd_de(deo[0])
    );

    lcd_timing #(
        .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .HS_ACTIVE_LOW(1'b1), .VS_ACTIVE_LOW(1'b1), .SYNC_DELAY(1)
    ) u_d1 (
        .clock(clk), .reset(reset), .pixel_enable(pixel_enable),
        .x(xo[1]), .y(yo[1]), .active(aco[1]), .frame_start(fso[1]),
        .lcd_hs(hso[1]), .lcd_vs(vso[1]), .lcd_de(deo[1])
    );

    lcd_timing #(
        .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .HS_ACTIVE_LOW(1'b1), .VS_ACTIVE_LOW(1'b1), .SYNC_DELAY(0)
    ) u_d0 (
        .clock(clk), .reset(reset), .pixel_enable(pixel_enable),
        .x(xo[2]), .y(yo[2]), .active(aco[2]), .frame_start(fso[2]),
        .lcd_hs(hso[2]), .lcd_vs(vso[2]), .lcd_de(deo[2])
    );

    lcd_timing #(
        .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .HS_ACTIVE_LOW(1'b0), .VS_ACTIVE_LOW(1'b1), .SYNC_DELAY(3)
    ) u_d3 (
        .clock(clk), .reset(reset), .pixel_enable(pixel_enable),
        .x(xo[3]), .y(yo[3]), .active(aco[3]), .frame_start(fso[3]),
        .lcd_hs(hso[3]), .lcd_vs(vso[3]), .lcd_de(deo[3])
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int h_total(input cfg_t c);
        return c.ha + c.hf + c.hsw + c.hb;
    endfunction

    function automatic int v_total(input cfg_t c);
        return c.va + c.vf + c.vsw + c.vb;
    endfunction

    // Raster position after n enabled cycles since reset.
    function automatic void xy_of(input cfg_t c, input int n, output int px, output int py);
        px = n % h_total(c);
        py = (n / h_total(c)) % v_total(c);
    endfunction

    // Panel pin levels {hs, vs, de} seen after n enabled cycles.
    function automatic logic [2:0] pins_of(input cfg_t c, input int n);
        int px, py;
        logic hs_on, vs_on, de_on;
        if (n < c.d) return {c.hal, c.val, 1'b0};
        xy_of(c, n - c.d, px, py);
        hs_on = (px >= c.ha + c.hf) && (px < c.ha + c.hf + c.hsw);
        vs_on = (py >= c.va + c.vf) && (py < c.va + c.vf + c.vsw);
        de_on = (px < c.ha) && (py < c.va);
        return {hs_on ^ c.hal, vs_on ^ c.val, de_on};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            n_en     <= 0;
            model_ok <= 1'b1;
        end else if (pixel_enable) begin
            n_en <= n_en + 1;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 4; i++) begin
                int ex, ey;
                logic [2:0] ep;
                xy_of(cfg[i], n_en, ex, ey);
                ep = pins_of(cfg[i], n_en);
                check($sformatf("x[%0d]", i), int'(xo[i]), ex);
                check($sformatf("y[%0d]", i), int'(yo[i]), ey);
                check($sformatf("active[%0d]", i), int'(aco[i]),
                      int'(ex < cfg[i].ha && ey < cfg[i].va));
                check($sformatf("frame_start[%0d]", i), int'(fso[i]),
                      int'(ex == 0 && ey == 0 && pixel_enable));
                check($sformatf("lcd_hs[%0d]", i), int'(hso[i]), int'(ep[2]));
                check($sformatf("lcd_vs[%0d]", i), int'(vso[i]), int'(ep[1]));
                check($sformatf("lcd_de[%0d]", i), int'(deo[i]), int'(ep[0]));
            end
        end
    end

    task automatic drive(input logic en, input logic rst);
        @(posedge clk);
        #2;
        pixel_enable = en;
        reset        = rst;
        @(negedge clk);
    endtask

    initial begin
        int hs_start, de_start, de_total;
        int fs_cnt, de_cnt1, vs_cnt1;
        int first_hs1, first_hs0, first_hs3;
        logic prev_hs0, prev_de0, prev_hs1, prev_hs2, prev_hs3;
        bit found;

        cfg[0] = '{800, 40, 48, 88, 480, 13, 3, 32, 1'b1, 1'b1, 1};
        cfg[1] = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1, 1'b1, 1};
        cfg[2] = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1, 1'b1, 0};
        cfg[3] = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b0, 1'b1, 3};

        // Reset state.
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        check("rst_x", int'(xo[0]), 0);
        check("rst_y", int'(yo[0]), 0);
        check("rst_active", int'(aco[0]), 1);
        check("rst_hs", int'(hso[0]), 1);
        check("rst_vs", int'(vso[0]), 1);
        check("rst_de", int'(deo[0]), 0);
        check("rst_fs_disabled", int'(fso[0]), 0);
        check("rst_hs_active_high", int'(hso[3]), 0);
        check("rst_de_delay0", int'(deo[2]), 1);

        // Continuous enable over three default lines and many small frames.
        hs_start = 0; de_start = 0; de_total = 0;
        fs_cnt = 0; de_cnt1 = 0; vs_cnt1 = 0;
        first_hs1 = -1; first_hs0 = -1; first_hs3 = -1;
        prev_hs0 = 1'b1; prev_de0 = 1'b0;
        prev_hs1 = 1'b1; prev_hs2 = 1'b1; prev_hs3 = 1'b0;
        for (int i = 0; i <= 2928; i++) begin
            drive(1'b1, 1'b0);
            if (i == 0) check("first_frame_start", int'(fso[0]), 1);
            if (i == 975) check("line0_last_x", int'(xo[0]), 975);
            if (i == 976) begin
                check("wrap_x", int'(xo[0]), 0);
                check("wrap_y", int'(yo[0]), 1);
            end
            if (prev_hs0 && !hso[0]) begin
                hs_start = i;
                check("hs_fall_x", int'(xo[0]), 841);
            end
            if (!prev_hs0 && hso[0]) check("hs_low_run", i - hs_start, 48);
            if (!prev_de0 && deo[0]) de_start = i;
            if (prev_de0 && !deo[0]) check("de_run", i - de_start, 800);
            de_total += int'(deo[0]);
            if (first_hs1 < 0 && prev_hs1 && !hso[1]) first_hs1 = i;
            if (first_hs0 < 0 && prev_hs2 && !hso[2]) first_hs0 = i;
            if (first_hs3 < 0 && !prev_hs3 && hso[3]) first_hs3 = i;
            if (i < 170) begin
                fs_cnt  += int'(fso[1]);
                de_cnt1 += int'(deo[1]);
                vs_cnt1 += int'(!vso[1]);
            end
            if (i == 170) begin
                check("frame_wrap_x", int'(xo[1]), 0);
                check("frame_wrap_y", int'(yo[1]), 0);
                check("frame_wrap_fs", int'(fso[1]), 1);
            end
            prev_hs0 = hso[0]; prev_de0 = deo[0];
            prev_hs1 = hso[1]; prev_hs2 = hso[2]; prev_hs3 = hso[3];
        end
        check("de_total_3_lines", de_total, 2400);
        check("small_fs_per_frame", fs_cnt, 1);
        check("small_de_per_frame", de_cnt1, 40);
        check("small_vs_low_per_frame", vs_cnt1, 34);
        check("hs_edge_delay1", first_hs1, 11);
        check("hs_edge_delay0", first_hs0, 10);
        check("hs_edge_delay3", first_hs3, 13);

        // Pseudo-random 50% enable; the model tracks holds and advances.
        for (int i = 0; i < 1200; i++) begin
            drive(logic'($urandom_range(0, 1)), 1'b0);
        end

        // One-cycle reset in the middle of active video of the small raster.
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            drive(1'b1, 1'b0);
            if (xo[1] == 10'd4 && yo[1] == 10'd2) found = 1'b1;
        end
        check("reset_point_reached", int'(found), 1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        check("midrst_x", int'(xo[1]), 0);
        check("midrst_y", int'(yo[1]), 0);
        check("midrst_fs", int'(fso[1]), 1);
        check("midrst_de", int'(deo[1]), 0);
        check("midrst_hs", int'(hso[1]), 1);
        check("midrst_vs", int'(vso[1]), 1);
        check("midrst_hs_active_high", int'(hso[3]), 0);
        check("midrst_de_delay3", int'(deo[3]), 0);
        check("midrst_de_delay0", int'(deo[2]), 1);
        check("midrst_dflt_de", int'(deo[0]), 0);

        repeat (400) drive(1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
